// File: rtl/run_ctl_pkg.sv
// Shared definitions for the CPU run controller.
//   STATE_W     : width of the debug state bus
//   run_state_e : run/halt/step FSM encodings (6 and 7 are unused)
package run_ctl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RST_HOLD  = 3'd0,
    WAIT_BOOT = 3'd1,
    BOOT      = 3'd2,
    RUN       = 3'd3,
    HALTED    = 3'd4,
    STEP      = 3'd5
  } run_state_e;

  // The CPU is held quiet (no interrupts) until it has been booted.
  function automatic logic int_allowed(input run_state_e s);
    return (s == RUN) || (s == HALTED) || (s == STEP);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector.
//   clk  : sampling clock
//   rst  : asynchronous active-high reset, clears every flop
//   d    : asynchronous input bits
//   rise : one-cycle pulse per bit on a synchronised 0->1 transition
module sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
      hist <= '0;
    end else begin
      meta <= d;
      sync <= meta;
      hist <= sync;
    end
  end

  assign rise = sync & ~hist;

endmodule

// File: rtl/cpu_run_ctl.sv
// CPU run/halt/single-step controller.
//   sysclk, reset           : clock and asynchronous active-high reset
//   boot                    : boot level, acted on at its rising edge
//   halt                    : halt request level
//   step, continue_req      : single-step / resume, rising-edge detected
//   interrupt, int_ack      : async interrupt line and CPU acknowledge
//   cpu_reset, cpu_boot     : stretched reset and boot command to the CPU
//   cpu_run                 : microsequencer run enable
//   cpu_int                 : latched pending interrupt
//   state                   : current FSM state for debug/LEDs
// Every output is a flop loaded from the next-state decode, so each one
// reflects the state entered at that clock edge.
module cpu_run_ctl
  import run_ctl_pkg::*;
#(
  parameter int RESET_STRETCH = 16,
  parameter int BOOT_CYCLES   = 4
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               boot,
  input  logic               halt,
  input  logic               step,
  input  logic               continue_req,
  input  logic               interrupt,
  input  logic               int_ack,
  output logic               cpu_reset,
  output logic               cpu_boot,
  output logic               cpu_run,
  output logic               cpu_int,
  output logic [STATE_W-1:0] state
);

  localparam int RW = $clog2(RESET_STRETCH) + 1;
  localparam int BW = $clog2(BOOT_CYCLES) + 1;
  localparam logic [RW-1:0] RST_LAST  = RW'(RESET_STRETCH - 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  run_state_e cur, nxt;
  logic [RW-1:0] rst_cnt;
  logic [BW-1:0] boot_cnt;

  logic boot_q, step_q, cont_q;
  logic boot_rise, step_rise, cont_rise, int_rise;

  // Console inputs are already synchronous: single-flop edge detect.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      boot_q <= 1'b0;
      step_q <= 1'b0;
      cont_q <= 1'b0;
    end else begin
      boot_q <= boot;
      step_q <= step;
      cont_q <= continue_req;
    end
  end

  assign boot_rise = boot & ~boot_q;
  assign step_rise = step & ~step_q;
  assign cont_rise = continue_req & ~cont_q;

  sync_edge #(.WIDTH(1)) u_int_sync (
    .clk  (sysclk),
    .rst  (reset),
    .d    (interrupt),
    .rise (int_rise)
  );

  // State register
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) cur <= RST_HOLD;
    else       cur <= nxt;
  end

  // Next state. Priority among RUN/HALTED/STEP: boot edge, halt, step,
  // continue. A halted CPU still accepts a step while halt is held.
  always_comb begin
    nxt = cur;
    case (cur)
      RST_HOLD:  if (rst_cnt == RST_LAST) nxt = WAIT_BOOT;
      WAIT_BOOT: if (boot_rise) nxt = BOOT;
      BOOT:      if (boot_cnt == BOOT_LAST) nxt = RUN;
      RUN: begin
        if (boot_rise) nxt = BOOT;
        else if (halt) nxt = HALTED;
      end
      HALTED: begin
        if (boot_rise)                nxt = BOOT;
        else if (step_rise)           nxt = STEP;
        else if (cont_rise && !halt)  nxt = RUN;
      end
      STEP: begin
        if (boot_rise) nxt = BOOT;
        else           nxt = HALTED;
      end
      default: nxt = RST_HOLD;
    endcase
  end

  // Dwell counters restart on every entry and stop at their terminal
  // count because the state exits there.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rst_cnt  <= '0;
      boot_cnt <= '0;
    end else begin
      rst_cnt  <= (cur == RST_HOLD && nxt == RST_HOLD) ? rst_cnt + RW'(1) : '0;
      boot_cnt <= (cur == BOOT && nxt == BOOT) ? boot_cnt + BW'(1) : '0;
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cpu_reset <= 1'b1;
      cpu_boot  <= 1'b0;
      cpu_run   <= 1'b0;
      cpu_int   <= 1'b0;
    end else begin
      cpu_reset <= (nxt == RST_HOLD);
      cpu_boot  <= (nxt == BOOT);
      cpu_run   <= (nxt == RUN) || (nxt == STEP);
      // A fresh edge beats a same-cycle acknowledge.
      if (!int_allowed(nxt)) cpu_int <= 1'b0;
      else if (int_rise)     cpu_int <= 1'b1;
      else if (int_ack)      cpu_int <= 1'b0;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_cpu_run_ctl.sv
module tb_cpu_run_ctl;
  localparam int RS = 16;
  localparam int BC = 4;

  logic sysclk = 1'b0;
  logic reset = 1'b0;
  logic boot = 1'b0, halt = 1'b0, step = 1'b0, continue_req = 1'b0;
  logic interrupt = 1'b0, int_ack = 1'b0;
  logic cpu_reset, cpu_boot, cpu_run, cpu_int;
  logic [2:0] state;

  cpu_run_ctl #(.RESET_STRETCH(RS), .BOOT_CYCLES(BC)) dut (
    .sysclk(sysclk), .reset(reset), .boot(boot), .halt(halt), .step(step),
    .continue_req(continue_req), .interrupt(interrupt), .int_ack(int_ack),
    .cpu_reset(cpu_reset), .cpu_boot(cpu_boot), .cpu_run(cpu_run),
    .cpu_int(cpu_int), .state(state)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0, failures = 0;
  int boot_hi = 0, run_hi = 0;

  // Reference model: mode numbers are the spec's state numbers; dwell
  // times are tracked as cycles remaining; the interrupt synchroniser is
  // a plain delay line of past samples.
  int   m_mode, m_rst_left, m_boot_left;
  logic m_pend, m_pb, m_ps, m_pc;
  logic [2:0] m_smp;

  task automatic model_reset();
    m_mode = 0; m_rst_left = RS; m_boot_left = 0; m_pend = 1'b0;
    m_pb = 1'b0; m_ps = 1'b0; m_pc = 1'b0; m_smp = 3'b000;
  endtask

  task automatic model_step(input logic r, b, h, s, c, i, a);
    logic rb, rs, rc, ri;
    int nm;
    if (r) begin model_reset(); return; end
    rb = b & ~m_pb; rs = s & ~m_ps; rc = c & ~m_pc;
    ri = m_smp[1] & ~m_smp[2];
    nm = m_mode;
    if (m_mode == 0) begin
      m_rst_left--;
      if (m_rst_left == 0) nm = 1;
    end else if (m_mode == 1) begin
      if (rb) begin nm = 2; m_boot_left = BC; end
    end else if (m_mode == 2) begin
      m_boot_left--;
      if (m_boot_left == 0) nm = 3;
    end else if (rb) begin
      nm = 2; m_boot_left = BC;
    end else if (m_mode == 3) begin
      if (h) nm = 4;
    end else if (m_mode == 4) begin
      if (rs) nm = 5;
      else if (rc && !h) nm = 3;
    end else begin
      nm = 4;
    end
    if (nm <= 2)  m_pend = 1'b0;
    else if (ri)  m_pend = 1'b1;
    else if (a)   m_pend = 1'b0;
    m_smp = {m_smp[1:0], i};
    m_pb = b; m_ps = s; m_pc = c;
    m_mode = nm;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string where);
    logic [7:0] act, exp;
    act = {cpu_reset, cpu_boot, cpu_run, cpu_int, 1'b0, state};
    exp = {m_mode == 0, m_mode == 2, (m_mode == 3) || (m_mode == 5), m_pend,
           1'b0, 3'(m_mode)};
    chk(where, 32'(act), 32'(exp));
  endtask

  task automatic tick();
    logic r, b, h, s, c, i, a;
    r = reset; b = boot; h = halt; s = step; c = continue_req;
    i = interrupt; a = int_ack;
    @(posedge sysclk);
    #1;
    model_step(r, b, h, s, c, i, a);
    check_model("model_cycle");
    boot_hi += 32'(cpu_boot);
    run_hi  += 32'(cpu_run);
  endtask

  // Reset changes land mid-cycle, away from any clock edge.
  task automatic set_reset_async(input logic v);
    #2 reset = v;
    #1;
    if (v) model_reset();
    check_model("async_reset");
  endtask

  task automatic run_reset_seq();
    set_reset_async(1'b0);
    for (int k = 1; k <= RS; k++) begin
      tick();
      chk($sformatf("stretch_k%0d", k), 32'(cpu_reset), 32'(k < RS));
    end
    chk("stretch_state", 32'(state), 32'd1);
    chk("stretch_run", 32'(cpu_run), 32'd0);
  endtask

  typedef struct {
    int n;
    logic b, h, s, c;
    logic [2:0] st;
    logic run;
    int bh, rh;
  } vec_t;

  vec_t tbl [16];
  int hold;

  initial begin
    //          n  b  h  s  c  st  run bh rh
    tbl[0]  = '{10, 1, 0, 0, 0, 3'd3, 1, 4, 6};
    tbl[1]  = '{1,  0, 0, 0, 0, 3'd3, 1, 0, 1};
    tbl[2]  = '{3,  0, 1, 0, 0, 3'd4, 0, 0, 0};
    tbl[3]  = '{1,  0, 1, 1, 0, 3'd5, 1, 0, 1};
    tbl[4]  = '{3,  0, 1, 0, 0, 3'd4, 0, 0, 0};
    tbl[5]  = '{5,  0, 1, 1, 0, 3'd4, 0, 0, 1};
    tbl[6]  = '{2,  0, 1, 0, 0, 3'd4, 0, 0, 0};
    tbl[7]  = '{1,  0, 1, 1, 1, 3'd5, 1, 0, 1};
    tbl[8]  = '{2,  0, 1, 0, 0, 3'd4, 0, 0, 0};
    tbl[9]  = '{2,  0, 1, 0, 1, 3'd4, 0, 0, 0};
    tbl[10] = '{1,  0, 0, 0, 0, 3'd4, 0, 0, 0};
    tbl[11] = '{2,  0, 0, 0, 1, 3'd3, 1, 0, 2};
    tbl[12] = '{1,  1, 0, 0, 0, 3'd2, 0, 1, 0};
    tbl[13] = '{2,  1, 0, 0, 0, 3'd2, 0, 2, 0};
    tbl[14] = '{1,  0, 0, 0, 0, 3'd2, 0, 1, 0};
    tbl[15] = '{1,  0, 0, 0, 0, 3'd3, 1, 0, 1};

    // Power-on reset
    model_reset();
    #1 reset = 1'b1;
    #2;
    check_model("reset_state");
    chk("reset_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reset_state_zero", 32'(state), 32'd0);
    repeat (5) tick();
    run_reset_seq();

    // Directed run/halt/step table
    for (int i = 0; i < 16; i++) begin
      boot = tbl[i].b; halt = tbl[i].h; step = tbl[i].s; continue_req = tbl[i].c;
      boot_hi = 0; run_hi = 0;
      repeat (tbl[i].n) tick();
      chk($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("row%0d_run", i), 32'(cpu_run), 32'(tbl[i].run));
      chk($sformatf("row%0d_boot_cycles", i), 32'(boot_hi), 32'(tbl[i].bh));
      chk($sformatf("row%0d_run_cycles", i), 32'(run_hi), 32'(tbl[i].rh));
    end

    // Interrupt latency, acknowledge, and set/ack collision (in RUN)
    interrupt = 1'b1; tick(); chk("irq_lat1", 32'(cpu_int), 32'd0);
    interrupt = 1'b0; tick(); chk("irq_lat2", 32'(cpu_int), 32'd0);
    tick(); chk("irq_lat3", 32'(cpu_int), 32'd1);
    int_ack = 1'b1; tick(); chk("irq_ack", 32'(cpu_int), 32'd0);
    int_ack = 1'b0; tick();
    interrupt = 1'b1; tick();
    interrupt = 1'b0; tick(); tick();
    chk("irq_set_again", 32'(cpu_int), 32'd1);
    interrupt = 1'b1; tick();
    interrupt = 1'b0; tick();
    int_ack = 1'b1; tick(); chk("irq_ack_collide", 32'(cpu_int), 32'd1);
    tick(); chk("irq_ack_after", 32'(cpu_int), 32'd0);
    int_ack = 1'b0;

    // Async reset in the second BOOT cycle
    boot = 1'b1; tick(); tick();
    chk("midboot_in_boot", 32'(state), 32'd2);
    set_reset_async(1'b1);
    chk("midboot_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("midboot_cpu_boot", 32'(cpu_boot), 32'd0);
    chk("midboot_state", 32'(state), 32'd0);
    boot = 1'b0;
    repeat (3) tick();
    run_reset_seq();
    boot = 1'b1; tick();
    chk("reboot_state", 32'(state), 32'd2);
    boot = 1'b0;

    // Randomised traffic against the model
    hold = 0;
    for (int n = 0; n < 4000; n++) begin
      if (reset) begin
        hold--;
        if (hold <= 0) set_reset_async(1'b0);
      end else if ($urandom_range(0, 399) == 0) begin
        set_reset_async(1'b1);
        hold = int'($urandom_range(1, 4));
      end
      if ($urandom_range(0, 19) == 0) boot = ~boot;
      if ($urandom_range(0, 7) == 0)  halt = ~halt;
      if ($urandom_range(0, 4) == 0)  interrupt = ~interrupt;
      step         = ($urandom_range(0, 3) == 0);
      continue_req = ($urandom_range(0, 2) == 0);
      int_ack      = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctl.md
Name: cpu_run_ctl

Overview:
- Sits directly downstream of the power-on/button support block.
- Consumes its reset and boot strobes, plus console halt/step/continue and the external interrupt line.
- Produces the CPU's stretched reset, one-shot boot command, microsequencer run-enable and a latched interrupt request.
- Owns the CPU run/halt/single-step state machine.

Parameters:
RESET_STRETCH, 16, cycles cpu_reset stays high after reset deasserts (>=1)
BOOT_CYCLES, 4, width in cycles of the cpu_boot pulse (>=1)

Ports:
sysclk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high reset (driven by support block)
boot  in  1  synchronous boot level from support block (multi-cycle, edge-detected)
halt  in  1  synchronous halt request level from console
step  in  1  synchronous single-step request, rising-edge detected
continue_req  in  1  synchronous resume request, rising-edge detected
interrupt  in  1  asynchronous external interrupt line
int_ack  in  1  synchronous CPU acknowledge, clears pending interrupt
cpu_reset  out  1  registered reset to CPU
cpu_boot  out  1  registered boot command to CPU
cpu_run  out  1  registered run/clock-enable to microsequencer
cpu_int  out  1  registered pending-interrupt flag
state  out  3  current FSM state (debug/LED)

Behaviour:
- Async reset values: cpu_reset=1, cpu_boot=0, cpu_run=0, cpu_int=0, state=RST_HOLD, stretch/boot counters=0, edge-detect history=0, interrupt sync flops=0.
- All outputs are registered and reflect the state entered at that edge; there are no combinational paths from inputs to outputs.
- Edge detect: rise(x) = x & ~x_q, where x_q is x registered each cycle. It applies to boot, step, continue_req and the synchronised interrupt.
- States: RST_HOLD=0, WAIT_BOOT=1, BOOT=2, RUN=3, HALTED=4, STEP=5; 6/7 are unused and recover to RST_HOLD.
- RST_HOLD: cpu_reset=1.
  - Counter increments from 0 each cycle after reset deasserts.
  - When the counter equals RESET_STRETCH-1, go to WAIT_BOOT, so cpu_reset is high for exactly RESET_STRETCH cycles after deassertion.
- WAIT_BOOT: cpu_reset=0, cpu_run=0; rise(boot) -> BOOT.
- BOOT: cpu_boot=1, cpu_run=0 for exactly BOOT_CYCLES cycles, then RUN. Further boot edges inside BOOT are ignored.
- RUN: cpu_run=1; halt=1 -> HALTED, so cpu_run is low from the next cycle.
- HALTED: cpu_run=0.
  - rise(step) -> STEP.
  - Otherwise rise(continue_req) with halt=0 -> RUN.
  - rise(continue_req) with halt=1 is ignored.
- STEP: cpu_run=1 for exactly one cycle, then HALTED unconditionally, even if halt=0.
- Priority in RUN/HALTED/STEP: rise(boot) > halt > step > continue_req. A boot edge restarts BOOT from any of these states.
- Interrupt path:
  - Two-flop synchroniser, then rise() sets pending.
  - int_ack=1 clears pending.
  - Set and ack in the same cycle: pending stays 1 (new edge wins).
  - Pending is forced 0 in RST_HOLD, WAIT_BOOT and BOOT.
  - cpu_int = pending.
  - Edge-to-cpu_int latency: 3 cycles from the first sysclk edge sampling interrupt high.
- Reset mid-operation: async assertion immediately forces the reset values in every state, including mid-BOOT or mid-STEP. The stretch counter is held at 0 while reset is high.
- Counters are sized to $clog2 of their parameter +1; no wrap is possible because each state exits on the terminal count.

Decomposition:
- Package run_ctl_pkg holds the state encodings (RST_HOLD..STEP) and the 3-bit state width constant.
- One sub-module, sync_edge: a parameterisable 2-flop synchroniser with rising-edge output, async active-high reset. It is used for interrupt.
- Boot, step and continue_req use the plain single-flop edge detect because they are already synchronous.

Test Plan:
- Reset high 5 cycles then low -> cpu_reset stays high exactly 16 further cycles, then state=1, cpu_run=0.
- In WAIT_BOOT, boot high 10 cycles -> single BOOT entry, cpu_boot high exactly 4 cycles, then cpu_run=1, state=3.
- In RUN, raise halt -> cpu_run=0 next cycle, state=4. Pulse step 1 cycle -> cpu_run high exactly 1 cycle, back to state=4. Hold step high 5 cycles -> still only one run cycle.
- HALTED with step and continue_req rising together -> STEP then HALTED. Then drop halt and pulse continue_req -> RUN.
- Async interrupt pulse -> cpu_int=1 three edges later. Assert int_ack -> cpu_int=0 next cycle. A new interrupt edge coinciding with int_ack -> cpu_int stays 1.
- Assert reset asynchronously mid-BOOT (cycle 2 of 4) -> cpu_reset=1, cpu_boot=0, state=0 immediately. Full RST_HOLD/WAIT_BOOT sequence repeats.
